// File: rtl/max_pool_seq_pkg.sv
// Shared activation-stage constants: default sample width and the zero-point/dummy value
// driven on idle data buses by relu_seq and the pooling stages.
package max_pool_seq_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_POOL_SIZE  = 4;

  localparam logic [DEF_DATA_WIDTH-1:0] ZERO_POINT = '0;

endpackage

// File: rtl/signed_max2.sv
// Two-input signed maximum, purely combinational (zero latency, no flow control).
// Ties return a, so a running maximum fed in on a stays put on equal samples.
module signed_max2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] max
);

  assign max = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/max_pool_seq.sv
// 1-D max pooling over non-overlapping windows of POOL_SIZE valid samples; result registered
// one cycle after the window's last sample. i_en=0 stalls every register, including o_valid.
module max_pool_seq
  import max_pool_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int POOL_SIZE  = DEF_POOL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data_bus,
  input  logic                  i_clear,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic                  o_busy
);

  localparam int                    CNT_WIDTH = $clog2(POOL_SIZE);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(POOL_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DUMMY     = DATA_WIDTH'(ZERO_POINT);

  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] run_max, run_max_nxt;
  logic [DATA_WIDTH-1:0] pool_max;
  logic                  close;
  logic                  o_valid_nxt;
  logic [DATA_WIDTH-1:0] o_data_nxt;

  signed_max2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_max (
    .a  (run_max),
    .b  (i_data_bus),
    .max(pool_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      run_max    <= DUMMY;
      o_valid    <= 1'b0;
      o_data_bus <= DUMMY;
    end else begin
      cnt        <= cnt_nxt;
      run_max    <= run_max_nxt;
      o_valid    <= o_valid_nxt;
      o_data_bus <= o_data_nxt;
    end
  end

  // A clear in the same cycle as a sample restarts the window at that sample.
  always_comb begin
    cnt_nxt     = cnt;
    run_max_nxt = run_max;
    if (i_en) begin
      if (i_clear) begin
        cnt_nxt     = '0;
        run_max_nxt = DUMMY;
      end
      if (i_valid) begin
        if (i_clear || cnt == '0) begin
          cnt_nxt     = CNT_ONE;
          run_max_nxt = i_data_bus;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt     = '0;
          run_max_nxt = DUMMY;
        end else begin
          cnt_nxt     = cnt + CNT_ONE;
          run_max_nxt = pool_max;
        end
      end
    end
  end

  always_comb begin
    close       = i_en & i_valid & ~i_clear & (cnt == CNT_LAST);
    o_valid_nxt = o_valid;
    o_data_nxt  = o_data_bus;
    if (i_en) begin
      o_valid_nxt = close;
      o_data_nxt  = close ? pool_max : DUMMY;
    end
  end

  assign o_busy = (cnt != '0);

endmodule

// File: tb/tb_max_pool_seq.sv
// Scoreboarded bench for max_pool_seq: directed windows push expected maxima, a monitor
// pops them on each fresh o_valid pulse and checks hold/idle behaviour every cycle.
module tb_max_pool_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_en;
  logic       i_valid;
  logic [7:0] i_data_bus;
  logic       i_clear;
  logic       o_valid;
  logic [7:0] o_data_bus;
  logic       o_busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  max_pool_seq #(
    .DATA_WIDTH(8),
    .POOL_SIZE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (i_en),
    .i_valid   (i_valid),
    .i_data_bus(i_data_bus),
    .i_clear   (i_clear),
    .o_valid   (o_valid),
    .o_data_bus(o_data_bus),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic en, input logic clr);
    i_valid    = v;
    i_data_bus = d;
    i_en       = en;
    i_clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: a registered result is fresh only if i_en was high at the edge that produced it.
  initial begin
    logic       en_q;
    logic       pv;
    logic [7:0] pd;
    logic [7:0] exp;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(posedge clk);
      en_q = i_en;
      @(negedge clk);
      if (!en_q) begin
        chk("hold_vld", {31'd0, o_valid}, {31'd0, pv});
        chk("hold_dat", {24'd0, o_data_bus}, {24'd0, pd});
      end else if (o_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_pulse: got data %0h, expected no pulse at %0t", o_data_bus, $time);
        end else begin
          exp = exp_q.pop_front();
          chk("pool_max", {24'd0, o_data_bus}, {24'd0, exp});
        end
      end else begin
        chk("idle_dat", {24'd0, o_data_bus}, 32'd0);
      end
      pv = o_valid;
      pd = o_data_bus;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    i_en       = 1'b1;
    i_valid    = 1'b1;
    i_data_bus = 8'h55;
    i_clear    = 1'b0;
    #12;
    chk("rst_vld", {31'd0, o_valid}, 32'd0);
    chk("rst_dat", {24'd0, o_data_bus}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    rst_n   = 1'b1;
    idle(3);
    chk("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // Basic window: 3, -5, 7, 2 -> 7
    exp_q.push_back(8'h07);
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    chk("busy_after_first", {31'd0, o_busy}, 32'd1);
    drive(1'b1, 8'hFB, 1'b1, 1'b0);
    drive(1'b1, 8'h07, 1'b1, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    chk("basic_close_vld", {31'd0, o_valid}, 32'd1);
    chk("basic_busy_after_close", {31'd0, o_busy}, 32'd0);
    idle(1);
    chk("basic_pulse_end", {31'd0, o_valid}, 32'd0);

    // All-negative window -> -1, then a continuous ramp.
    exp_q.push_back(8'hFF);
    drive(1'b1, 8'h80, 1'b1, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    drive(1'b1, 8'hFE, 1'b1, 1'b0);
    drive(1'b1, 8'hFD, 1'b1, 1'b0);
    chk("neg_close_vld", {31'd0, o_valid}, 32'd1);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h0F);
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    chk("ramp_last_vld", {31'd0, o_valid}, 32'd1);
    idle(2);

    // Gaps inside the window.
    exp_q.push_back(8'h14);
    drive(1'b1, 8'h0A, 1'b1, 1'b0);
    drive(1'b1, 8'h14, 1'b1, 1'b0);
    idle(3);
    chk("gap_busy", {31'd0, o_busy}, 32'd1);
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    chk("gap_close_vld", {31'd0, o_valid}, 32'd1);
    idle(2);

    // Stall right after the close holds the pulse.
    exp_q.push_back(8'h14);
    drive(1'b1, 8'h0A, 1'b1, 1'b0);
    drive(1'b1, 8'h14, 1'b1, 1'b0);
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stall_vld", {31'd0, o_valid}, 32'd1);
    chk("stall_dat", {24'd0, o_data_bus}, 32'h14);
    idle(1);
    chk("stall_release_vld", {31'd0, o_valid}, 32'd0);
    idle(1);

    // Clear with a simultaneous sample starts a fresh window.
    exp_q.push_back(8'h08);
    drive(1'b1, 8'h64, 1'b1, 1'b0);
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    drive(1'b1, 8'h04, 1'b1, 1'b1);
    chk("clear_busy", {31'd0, o_busy}, 32'd1);
    drive(1'b1, 8'h06, 1'b1, 1'b0);
    drive(1'b1, 8'h08, 1'b1, 1'b0);
    chk("clear_no_early_pulse", {31'd0, o_valid}, 32'd0);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    chk("clear_close_vld", {31'd0, o_valid}, 32'd1);
    idle(2);

    // Reset in the middle of a window.
    exp_q.push_back(8'h04);
    drive(1'b1, 8'h32, 1'b1, 1'b0);
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_vld", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    drive(1'b1, 8'h04, 1'b1, 1'b0);
    chk("midrst_close_vld", {31'd0, o_valid}, 32'd1);
    idle(4);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
